struct96_frame_packer: RTL and testbench

- Upstream feeder for the packed-struct consumer stage.
- Accepts a 32-bit word stream (valid/ready, last-marked) and assembles each 3-word frame into one `struct96_t` value.
- Emits a companion `struct_t` status pair alongside each frame: error flag and parity.
- Registered output with valid/ready handshake, frame counter and saturating error counter.

---
 rtl/struct96_frame_packer.sv | 208 ++++++++++++++++++++
 tb/tb_struct96_frame_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/struct96_frame_packer.sv
// struct96_frame_packer: collects 3-word frames from a 32-bit valid/ready
// stream into one registered 96-bit struct96_t value, paired with a struct_t
// status (frame error, parity). Also keeps a wrapping frame counter and a
// saturating error counter.
module struct96_frame_packer #(
  parameter int WORD_W    = 32,
  parameter int ERR_CNT_W = 8,
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WORD_W-1:0]  t96,
  output logic [1:0]           test_input,
  output logic [FRM_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int FRAME_W = 3 * WORD_W;

  // The struct96_t layout is hard-wired to three 32-bit words.
  if (WORD_W != 32) begin : g_word_w_check
    $error("struct96_frame_packer: WORD_W must be 32");
  end

  // Consumer-facing packed types.
  typedef struct packed {
    logic [94:0] m_1;
    logic        m_2;
  } struct96_t;

  typedef struct packed {
    logic m_1;  // frame error
    logic m_2;  // parity of the 96 frame bits
  } struct_t;

  // Next word index, or discarding the tail of an over-long frame.
  typedef enum logic [1:0] {
    S_W0    = 2'd0,
    S_W1    = 2'd1,
    S_W2    = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Reset synchroniser: rst_n asserts asynchronously, releases on clk.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Two-flop release chain for the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // State and assembly registers
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word0_q, word0_d;
  logic [WORD_W-1:0]   word1_q, word1_d;

  logic                out_valid_q;
  struct96_t           t96_q;
  struct_t             status_q;
  logic [FRM_CNT_W-1:0] frame_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                beat;
  logic                frame_done;
  logic                frame_err;
  logic [FRAME_W-1:0]  frame_bits;

  // While draining, words are thrown away and never touch the output, so the
  // held frame does not need to be consumed first.
  assign in_ready = (state_q == S_DRAIN) || !out_valid_q || out_ready;
  assign beat     = in_valid && in_ready;

  // State register plus the two stored leading words of the current frame.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_W0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      state_q <= state_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
    end
  end

  // Next-state logic and frame completion decode.
  always_comb begin
    state_d    = state_q;
    word0_d    = word0_q;
    word1_d    = word1_q;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    frame_bits = '0;

    case (state_q)
      S_W0: begin
        if (beat) begin
          word0_d = in_data;
          if (in_last) begin
            // Short frame: one word, the rest zero-filled.
            frame_done = 1'b1;
            frame_err  = 1'b1;
            frame_bits = {in_data, {(2*WORD_W){1'b0}}};
            state_d    = S_W0;
          end else begin
            state_d = S_W1;
          end
        end
      end

      S_W1: begin
        if (beat) begin
          word1_d = in_data;
          if (in_last) begin
            // Short frame: two words, last one zero-filled.
            frame_done = 1'b1;
            frame_err  = 1'b1;
            frame_bits = {word0_q, in_data, {WORD_W{1'b0}}};
            state_d    = S_W0;
          end else begin
            state_d = S_W2;
          end
        end
      end

      S_W2: begin
        if (beat) begin
          // Third word always closes the frame; a missing last means the
          // frame is too long and its tail must be discarded.
          frame_done = 1'b1;
          frame_err  = !in_last;
          frame_bits = {word0_q, word1_q, in_data};
          state_d    = in_last ? S_W0 : S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (beat && in_last) begin
          state_d = S_W0;
        end
      end

      default: begin
        state_d = S_W0;
      end
    endcase
  end

  // Output frame register: load on completion, otherwise release on consume.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_valid_q <= 1'b0;
      t96_q       <= '0;
      status_q    <= '0;
    end else if (frame_done) begin
      // A completing beat is only possible when the held frame is empty or
      // being consumed this cycle, so overwriting here never loses data.
      out_valid_q  <= 1'b1;
      t96_q        <= frame_bits;
      status_q.m_1 <= frame_err;
      status_q.m_2 <= ^frame_bits;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Wrapping count of frames emitted.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + FRM_CNT_W'(1);
    end
  end

  // Saturating count of error frames emitted.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      err_cnt_q <= '0;
    end else if (frame_done && frame_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign out_valid  = out_valid_q;
  assign t96        = t96_q;
  assign test_input = status_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_struct96_frame_packer.sv
// Self-checking bench for struct96_frame_packer: directed scenarios plus
// randomized frames, all compared against a frame-level reference model.
module tb_struct96_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] t96;
  logic [1:0]  test_input;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  struct96_frame_packer #(
    .WORD_W    (32),
    .ERR_CNT_W (8),
    .FRM_CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .t96        (t96),
    .test_input (test_input),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: frames as lists of words
  // ------------------------------------------------------------------
  typedef struct {
    logic [95:0] bits;
    logic [1:0]  st;
    logic [15:0] fc;
    logic [7:0]  ec;
  } frm_t;

  frm_t        pend[$];
  logic [31:0] cur[$];
  bit          draining = 1'b0;
  logic [15:0] m_fc = '0;
  logic [7:0]  m_ec = '0;
  bit          mon_en = 1'b0;

  task automatic model_word(input logic [31:0] d, input logic last);
    frm_t        f;
    logic [95:0] v;
    bit          err;
    if (draining) begin
      if (last) draining = 1'b0;
    end else begin
      cur.push_back(d);
      if (last || cur.size() == 3) begin
        v = '0;
        for (int i = 0; i < 3; i++) begin
          v = {v[63:0], (i < cur.size()) ? cur[i] : 32'h0};
        end
        err = !(cur.size() == 3 && last);
        if (cur.size() == 3 && !last) draining = 1'b1;
        m_fc = m_fc + 16'd1;
        if (err && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        f.bits = v;
        f.st   = {err, ^v};
        f.fc   = m_fc;
        f.ec   = m_ec;
        pend.push_back(f);
        cur.delete();
      end
    end
  endtask

  // Compare against the model each cycle, then advance the model by the
  // handshakes that happen at the coming edge.
  always @(negedge clk) begin : mon
    bit er;
    if (mon_en) begin
      er = draining || (pend.size() == 0) || out_ready;
      check_eq("in_ready", in_ready, er);
      check_eq("out_valid", out_valid, pend.size() != 0);
      if (pend.size() != 0) begin
        check_eq("t96", t96, pend[0].bits);
        check_eq("test_input", test_input, pend[0].st);
        check_eq("frame_cnt", frame_cnt, pend[0].fc);
        check_eq("err_cnt", err_cnt, pend[0].ec);
        if (out_ready) void'(pend.pop_front());
      end
      if (in_valid && er) model_word(in_data, in_last);
    end
  end

  // ------------------------------------------------------------------
  // out_ready driver: fixed value or random per cycle
  // ------------------------------------------------------------------
  int rdy_mode = 0;
  bit rdy_val  = 1'b1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Present one word and wait until it is accepted (bounded).
  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 2000) begin
        check_eq("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_t96", t96, 96'h0);
    check_eq("rst_test_input", test_input, 2'b00);
    check_eq("rst_frame_cnt", frame_cnt, 16'h0);
    check_eq("rst_err_cnt", err_cnt, 8'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cur.delete();
    pend.delete();
    draining = 1'b0;
    m_fc     = '0;
    m_ec     = '0;
    mon_en   = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [95:0] nom;
  logic [95:0] bp_a;
  int          len;

  initial begin
    nom  = 96'hDEADBEEF_01234567_89ABCDEF;
    bp_a = 96'h11112222_33334444_55556666;
    rdy_mode = 0;
    rdy_val  = 1'b1;
    #1;
    do_reset();

    // Reset in the middle of a frame discards the partial word.
    send_word(32'hCAFEF00D, 1'b0);
    idle(1);
    do_reset();

    // Nominal frame straight after reset.
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h01234567, 1'b0);
    send_word(32'h89ABCDEF, 1'b1);
    check_eq("nom_valid", out_valid, 1'b1);
    check_eq("nom_t96", t96, nom);
    check_eq("nom_status", test_input, {1'b0, ^nom});
    check_eq("nom_frame_cnt", frame_cnt, 16'd1);
    idle(2);

    // Short frame.
    send_word(32'hFFFFFFFF, 1'b1);
    check_eq("short_t96", t96, 96'hFFFFFFFF_00000000_00000000);
    check_eq("short_status", test_input, 2'b10);
    check_eq("short_err_cnt", err_cnt, 8'd1);
    idle(2);

    // Long frame: error after word 3, words 4-5 dropped, then a clean frame.
    send_word(32'hA0000001, 1'b0);
    send_word(32'hA0000002, 1'b0);
    send_word(32'hA0000003, 1'b0);
    check_eq("long_err_flag", test_input[1], 1'b1);
    check_eq("long_t96", t96, 96'hA0000001_A0000002_A0000003);
    send_word(32'hA0000004, 1'b0);
    send_word(32'hA0000005, 1'b1);
    send_word(32'h0000000A, 1'b0);
    send_word(32'h0000000B, 1'b0);
    send_word(32'h0000000C, 1'b1);
    check_eq("post_long_t96", t96, 96'h0000000A_0000000B_0000000C);
    check_eq("post_long_status", test_input[1], 1'b0);
    idle(2);

    // Backpressure, then consume and complete in the same cycle.
    rdy_val = 1'b0;
    idle(1);
    send_word(bp_a[95:64], 1'b0);
    send_word(bp_a[63:32], 1'b0);
    send_word(bp_a[31:0], 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h77777777;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_t96_hold", t96, bp_a);
    end
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    send_word(32'h77777777, 1'b1);
    check_eq("bp_valid_kept", out_valid, 1'b1);
    check_eq("bp_new_t96", t96, 96'h77777777_00000000_00000000);
    idle(2);

    // Randomized frames with random backpressure and idle gaps.
    rdy_mode = 1;
    for (int f = 0; f < 400; f++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        send_word($urandom, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rdy_mode = 0;
    rdy_val  = 1'b1;
    idle(4);

    // Error counter saturation.
    for (int i = 0; i < 256; i++) send_word($urandom, 1'b1);
    check_eq("err_cnt_sat", err_cnt, 8'hFF);
    send_word($urandom, 1'b1);
    check_eq("err_cnt_sat_hold", err_cnt, 8'hFF);

    // Frame counter wrap.
    while (m_fc != 16'hFFFF) send_word($urandom, 1'b1);
    idle(1);
    check_eq("frame_cnt_max", frame_cnt, 16'hFFFF);
    send_word(32'h12345678, 1'b1);
    check_eq("frame_cnt_wrap", frame_cnt, 16'h0000);
    idle(4);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
